// File: rtl/g_round_sched_pkg.sv
// g_round_sched_pkg: shared types and tables for the round scheduler.
// FSM states, message permutation, column/diagonal lane word indices.
package g_round_sched_pkg;

  localparam int WORD_W  = 32;
  localparam int N_WORDS = 16;
  localparam int N_LANES = 4;
  localparam int LANE_W  = WORD_W * N_LANES;
  localparam int BLK_W   = WORD_W * N_WORDS;

  typedef logic [3:0] idx_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } fsm_e;

  // m'[i] = m[PERM[i]]
  localparam idx_t PERM [N_WORDS] = '{
    4'd2,  4'd6,  4'd3,  4'd10,
    4'd7,  4'd0,  4'd4,  4'd13,
    4'd1,  4'd11, 4'd12, 4'd5,
    4'd9,  4'd14, 4'd15, 4'd8
  };

  // [lane][a,b,c,d] -> working-state word index
  localparam idx_t COL_IDX [N_LANES][4] = '{
    '{4'd0, 4'd4, 4'd8,  4'd12},
    '{4'd1, 4'd5, 4'd9,  4'd13},
    '{4'd2, 4'd6, 4'd10, 4'd14},
    '{4'd3, 4'd7, 4'd11, 4'd15}
  };

  localparam idx_t DIAG_IDX [N_LANES][4] = '{
    '{4'd0, 4'd5, 4'd10, 4'd15},
    '{4'd1, 4'd6, 4'd11, 4'd12},
    '{4'd2, 4'd7, 4'd8,  4'd13},
    '{4'd3, 4'd4, 4'd9,  4'd14}
  };

  function automatic logic [WORD_W-1:0] word_at(
    input logic [BLK_W-1:0] blk,
    input idx_t             i
  );
    return blk[WORD_W*i +: WORD_W];
  endfunction

endpackage

// File: rtl/g_lane_map.sv
// g_lane_map: gathers state/message words into four G-lane operand sets
// and scatters lane results back to state-word write enables and data.
// Ports: i_gdiag/i_v/i_m -> o_a..o_y; i_sdiag/i_ra..i_rd -> o_we/o_wdata.
module g_lane_map
  import g_round_sched_pkg::*;
(
  input  logic                i_gdiag,
  input  logic [BLK_W-1:0]    i_v,
  input  logic [BLK_W-1:0]    i_m,
  output logic [LANE_W-1:0]   o_a,
  output logic [LANE_W-1:0]   o_b,
  output logic [LANE_W-1:0]   o_c,
  output logic [LANE_W-1:0]   o_d,
  output logic [LANE_W-1:0]   o_x,
  output logic [LANE_W-1:0]   o_y,
  input  logic                i_sdiag,
  input  logic [LANE_W-1:0]   i_ra,
  input  logic [LANE_W-1:0]   i_rb,
  input  logic [LANE_W-1:0]   i_rc,
  input  logic [LANE_W-1:0]   i_rd,
  output logic [N_WORDS-1:0]  o_we,
  output logic [BLK_W-1:0]    o_wdata
);

  logic [LANE_W-1:0] w_res [4];

  assign w_res[0] = i_ra;
  assign w_res[1] = i_rb;
  assign w_res[2] = i_rc;
  assign w_res[3] = i_rd;

  always_comb begin
    o_a = '0;
    o_b = '0;
    o_c = '0;
    o_d = '0;
    o_x = '0;
    o_y = '0;
    for (int j = 0; j < N_LANES; j++) begin
      if (i_gdiag) begin
        o_a[WORD_W*j +: WORD_W] = word_at(i_v, DIAG_IDX[j][0]);
        o_b[WORD_W*j +: WORD_W] = word_at(i_v, DIAG_IDX[j][1]);
        o_c[WORD_W*j +: WORD_W] = word_at(i_v, DIAG_IDX[j][2]);
        o_d[WORD_W*j +: WORD_W] = word_at(i_v, DIAG_IDX[j][3]);
      end else begin
        o_a[WORD_W*j +: WORD_W] = word_at(i_v, COL_IDX[j][0]);
        o_b[WORD_W*j +: WORD_W] = word_at(i_v, COL_IDX[j][1]);
        o_c[WORD_W*j +: WORD_W] = word_at(i_v, COL_IDX[j][2]);
        o_d[WORD_W*j +: WORD_W] = word_at(i_v, COL_IDX[j][3]);
      end
      // column uses m[2j], m[2j+1]; diagonal uses m[8+2j], m[9+2j]
      o_x[WORD_W*j +: WORD_W] =
        word_at(i_m, idx_t'(2*j + (i_gdiag ? 8 : 0)));
      o_y[WORD_W*j +: WORD_W] =
        word_at(i_m, idx_t'(2*j + (i_gdiag ? 9 : 1)));
    end
  end

  always_comb begin
    idx_t v_i;
    v_i     = '0;
    o_we    = '0;
    o_wdata = '0;
    for (int j = 0; j < N_LANES; j++) begin
      for (int k = 0; k < 4; k++) begin
        v_i = i_sdiag ? DIAG_IDX[j][k] : COL_IDX[j][k];
        o_we[v_i] = 1'b1;
        o_wdata[WORD_W*v_i +: WORD_W] =
          w_res[k][WORD_W*j +: WORD_W];
      end
    end
  end

endmodule

// File: rtl/g_round_sched.sv
// g_round_sched: sequences column/diagonal G steps over external lanes.
// Ports: Start_I/State_I/Msg_I in, Ready/Busy/Done/State_O out, G_* lanes.
module g_round_sched
  import g_round_sched_pkg::*;
#(
  parameter int NUM_ROUNDS = 7,
  parameter int G_LATENCY  = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start_I,
  input  logic [BLK_W-1:0]  State_I,
  input  logic [BLK_W-1:0]  Msg_I,
  output logic              Ready_O,
  output logic              Busy_O,
  output logic              Done_O,
  output logic [BLK_W-1:0]  State_O,
  output logic [LANE_W-1:0] G_A_O,
  output logic [LANE_W-1:0] G_B_O,
  output logic [LANE_W-1:0] G_C_O,
  output logic [LANE_W-1:0] G_D_O,
  output logic [LANE_W-1:0] G_X_O,
  output logic [LANE_W-1:0] G_Y_O,
  input  logic [LANE_W-1:0] G_A_I,
  input  logic [LANE_W-1:0] G_B_I,
  input  logic [LANE_W-1:0] G_C_I,
  input  logic [LANE_W-1:0] G_D_I
);

  localparam logic [7:0] CNT_LAST = 8'(G_LATENCY - 1);
  localparam logic [3:0] RND_LAST = 4'(NUM_ROUNDS);

  fsm_e              r_fsm;
  logic [BLK_W-1:0]  r_v;
  logic [BLK_W-1:0]  r_m;
  logic              r_diag;
  logic [3:0]        r_round;
  logic [7:0]        r_cnt;

  logic [7:0]        w_cnt_nxt;
  logic [3:0]        w_round_nxt;
  logic              w_cap;
  logic              w_last;
  logic              w_accept;
  logic              w_gload;
  logic              w_gdiag;
  logic [BLK_W-1:0]  w_gsrc_v;
  logic [BLK_W-1:0]  w_gsrc_m;
  logic [BLK_W-1:0]  w_m_perm;
  logic [BLK_W-1:0]  w_m_next;
  logic [BLK_W-1:0]  w_v_wb;
  logic [N_WORDS-1:0] w_we;
  logic [BLK_W-1:0]  w_wdata;
  logic [LANE_W-1:0] w_ga, w_gb, w_gc, w_gd, w_gx, w_gy;

  assign w_cnt_nxt   = r_cnt + 8'd1;
  assign w_round_nxt = r_round + 4'd1;
  assign w_cap       = (r_fsm == S_CAPTURE);
  assign w_last      = r_diag && (w_round_nxt == RND_LAST);
  assign w_accept    = (r_fsm == S_IDLE) && Start_I;
  assign w_gload     = w_accept || (w_cap && !w_last);

  // Operands for the next step are gathered one cycle early (at accept
  // or capture) so the lane outputs can be registered yet valid in ISSUE.
  assign w_m_next = r_diag ? w_m_perm : r_m;
  assign w_gsrc_v = w_cap ? w_v_wb : State_I;
  assign w_gsrc_m = w_cap ? w_m_next : Msg_I;
  assign w_gdiag  = w_cap && !r_diag;

  always_comb begin
    w_m_perm = '0;
    for (int i = 0; i < N_WORDS; i++)
      w_m_perm[WORD_W*i +: WORD_W] = word_at(r_m, PERM[i]);
  end

  always_comb begin
    w_v_wb = r_v;
    for (int i = 0; i < N_WORDS; i++)
      if (w_we[i])
        w_v_wb[WORD_W*i +: WORD_W] = w_wdata[WORD_W*i +: WORD_W];
  end

  g_lane_map u_map (
    .i_gdiag (w_gdiag),
    .i_v     (w_gsrc_v),
    .i_m     (w_gsrc_m),
    .o_a     (w_ga),
    .o_b     (w_gb),
    .o_c     (w_gc),
    .o_d     (w_gd),
    .o_x     (w_gx),
    .o_y     (w_gy),
    .i_sdiag (r_diag),
    .i_ra    (G_A_I),
    .i_rb    (G_B_I),
    .i_rc    (G_C_I),
    .i_rd    (G_D_I),
    .o_we    (w_we),
    .o_wdata (w_wdata)
  );

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      G_A_O <= '0;
      G_B_O <= '0;
      G_C_O <= '0;
      G_D_O <= '0;
      G_X_O <= '0;
      G_Y_O <= '0;
    end else if (w_gload) begin
      G_A_O <= w_ga;
      G_B_O <= w_gb;
      G_C_O <= w_gc;
      G_D_O <= w_gd;
      G_X_O <= w_gx;
      G_Y_O <= w_gy;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_fsm   <= S_IDLE;
      r_v     <= '0;
      r_m     <= '0;
      r_diag  <= 1'b0;
      r_round <= '0;
      r_cnt   <= '0;
      Ready_O <= 1'b1;
      Busy_O  <= 1'b0;
      Done_O  <= 1'b0;
      State_O <= '0;
    end else begin
      unique case (r_fsm)
        S_IDLE: begin
          if (Start_I) begin
            r_v     <= State_I;
            r_m     <= Msg_I;
            r_diag  <= 1'b0;
            r_round <= '0;
            r_cnt   <= '0;
            Ready_O <= 1'b0;
            Busy_O  <= 1'b1;
            r_fsm   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt <= '0;
          r_fsm <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= w_cnt_nxt;
          if (w_cnt_nxt == CNT_LAST)
            r_fsm <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_v    <= w_v_wb;
          r_m    <= w_m_next;
          r_diag <= !r_diag;
          if (r_diag)
            r_round <= w_round_nxt;
          if (w_last) begin
            State_O <= w_v_wb;
            Done_O  <= 1'b1;
            Busy_O  <= 1'b0;
            r_fsm   <= S_DONE;
          end else begin
            r_fsm <= S_ISSUE;
          end
        end
        S_DONE: begin
          Done_O  <= 1'b0;
          Ready_O <= 1'b1;
          r_fsm   <= S_IDLE;
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_g_round_sched.sv
// tb_g_round_sched: scoreboard bench with 4-cycle G lane models and a
// reference compression model; two DUTs (7 rounds and 1 round).
module tb_g_round_sched;

  typedef struct {
    logic [511:0] st;
    int           at;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         st0, st1;
  logic [511:0] si0, mi0, si1, mi1;
  logic         rdy0, bsy0, dn0, rdy1, bsy1, dn1;
  logic [511:0] so0, so1;
  logic [127:0] ga0, gb0, gc0, gd0, gx0, gy0;
  logic [127:0] ra0, rb0, rc0, rd0;
  logic [127:0] ga1, gb1, gc1, gd1, gx1, gy1;
  logic [127:0] ra1, rb1, rc1, rd1;

  int  n_chk = 0;
  int  n_err = 0;
  int  cyc   = 0;
  int  t0    = 0;
  sb_t q0[$];
  sb_t q1[$];
  sb_t e0, e1;

  g_round_sched #(.NUM_ROUNDS(7), .G_LATENCY(4)) dut (
    .Clk(clk), .Rst_n(rst_n), .Start_I(st0),
    .State_I(si0), .Msg_I(mi0),
    .Ready_O(rdy0), .Busy_O(bsy0), .Done_O(dn0), .State_O(so0),
    .G_A_O(ga0), .G_B_O(gb0), .G_C_O(gc0), .G_D_O(gd0),
    .G_X_O(gx0), .G_Y_O(gy0),
    .G_A_I(ra0), .G_B_I(rb0), .G_C_I(rc0), .G_D_I(rd0)
  );

  g_round_sched #(.NUM_ROUNDS(1), .G_LATENCY(4)) dut1 (
    .Clk(clk), .Rst_n(rst_n), .Start_I(st1),
    .State_I(si1), .Msg_I(mi1),
    .Ready_O(rdy1), .Busy_O(bsy1), .Done_O(dn1), .State_O(so1),
    .G_A_O(ga1), .G_B_O(gb1), .G_C_O(gc1), .G_D_O(gd1),
    .G_X_O(gx1), .G_Y_O(gy1),
    .G_A_I(ra1), .G_B_I(rb1), .G_C_I(rc1), .G_D_I(rd1)
  );

  task automatic chk(input string tag,
                     input logic [511:0] got,
                     input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] v,
                                       input int n);
    return (v >> n) | (v << (32 - n));
  endfunction

  function automatic logic [127:0] gmix(
    input logic [31:0] a0, b0, c0, d0, x, y);
    logic [31:0] a, b, c, d;
    a = a0 + b0 + x;
    d = rotr(d0 ^ a, 16);
    c = c0 + d;
    b = rotr(b0 ^ c, 12);
    a = a + b + y;
    d = rotr(d ^ a, 8);
    c = c + d;
    b = rotr(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  // result layout: [127:0]=A lanes, [255:128]=B, [383:256]=C, [511:384]=D
  function automatic logic [511:0] lanes_g(
    input logic [127:0] a, b, c, d, x, y);
    logic [511:0] r;
    logic [127:0] g;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      g = gmix(a[32*j +: 32], b[32*j +: 32], c[32*j +: 32],
               d[32*j +: 32], x[32*j +: 32], y[32*j +: 32]);
      r[32*j +: 32]       = g[127:96];
      r[128 + 32*j +: 32] = g[95:64];
      r[256 + 32*j +: 32] = g[63:32];
      r[384 + 32*j +: 32] = g[31:0];
    end
    return r;
  endfunction

  function automatic logic [511:0] ref_run(input logic [511:0] s,
                                           input logic [511:0] m,
                                           input int rounds);
    logic [31:0]  v[16];
    logic [31:0]  w[16];
    logic [31:0]  t[16];
    int           p[16];
    int           ix[4];
    logic [127:0] r;
    logic [511:0] o;
    p = '{2, 6, 3, 10, 7, 0, 4, 13, 1, 11, 12, 5, 9, 14, 15, 8};
    for (int i = 0; i < 16; i++) begin
      v[i] = s[32*i +: 32];
      w[i] = m[32*i +: 32];
    end
    for (int rd = 0; rd < rounds; rd++) begin
      for (int st = 0; st < 2; st++) begin
        for (int j = 0; j < 4; j++) begin
          if (st == 0)
            ix = '{j, 4 + j, 8 + j, 12 + j};
          else
            ix = '{j, 4 + (j + 1) % 4, 8 + (j + 2) % 4,
                   12 + (j + 3) % 4};
          r = gmix(v[ix[0]], v[ix[1]], v[ix[2]], v[ix[3]],
                   w[8*st + 2*j], w[8*st + 2*j + 1]);
          v[ix[0]] = r[127:96];
          v[ix[1]] = r[95:64];
          v[ix[2]] = r[63:32];
          v[ix[3]] = r[31:0];
        end
      end
      for (int i = 0; i < 16; i++) t[i] = w[p[i]];
      w = t;
    end
    for (int i = 0; i < 16; i++) o[32*i +: 32] = v[i];
    return o;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // 4-cycle G lane models
  logic [511:0] p0 [4];
  logic [511:0] p1 [4];

  always @(posedge clk) begin
    p0[0] <= lanes_g(ga0, gb0, gc0, gd0, gx0, gy0);
    p1[0] <= lanes_g(ga1, gb1, gc1, gd1, gx1, gy1);
    for (int i = 1; i < 4; i++) begin
      p0[i] <= p0[i-1];
      p1[i] <= p1[i-1];
    end
  end

  assign {rd0, rc0, rb0, ra0} = p0[3];
  assign {rd1, rc1, rb1, ra1} = p1[3];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && dn0 === 1'b1) begin
      chk("u0_done_expected", 512'(q0.size() > 0), 512'd1);
      if (q0.size() > 0) begin
        e0 = q0.pop_front();
        chk("u0_state", so0, e0.st);
        chk("u0_done_cyc", 512'(cyc), 512'(e0.at));
      end
    end
    if (rst_n === 1'b1 && dn1 === 1'b1) begin
      chk("u1_done_expected", 512'(q1.size() > 0), 512'd1);
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        chk("u1_state", so1, e1.st);
        chk("u1_done_cyc", 512'(cyc), 512'(e1.at));
      end
    end
  end

  task automatic at_cyc(input int n);
    while (cyc < t0 + n) @(negedge clk);
  endtask

  task automatic start_job(input int u,
                           input logic [511:0] s,
                           input logic [511:0] m);
    sb_t e;
    @(negedge clk);
    if (u == 0) begin
      st0 = 1'b1; si0 = s; mi0 = m;
    end else begin
      st1 = 1'b1; si1 = s; mi1 = m;
    end
    @(posedge clk);
    #1;
    t0 = cyc - 1;
    if (u == 0) begin
      e.st = ref_run(s, m, 7);
      e.at = t0 + 71;
      q0.push_back(e);
    end else begin
      e.st = ref_run(s, m, 1);
      e.at = t0 + 11;
      q1.push_back(e);
    end
    @(negedge clk);
    st0 = 1'b0;
    st1 = 1'b0;
  endtask

  task automatic drain(input int u, input int max);
    int k;
    k = 0;
    while (((u == 0) ? q0.size() : q1.size()) != 0 && k < max) begin
      @(negedge clk);
      k++;
    end
    chk(u == 0 ? "u0_drained" : "u1_drained",
        512'((u == 0) ? q0.size() : q1.size()), 512'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] mi, sa, sb, sc, sd, ea;
    sb_t e;
    rst_n = 1'b0;
    st0 = 1'b0; st1 = 1'b0;
    si0 = '0; mi0 = '0; si1 = '0; mi1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 512'({rdy0, rdy1}), 512'd3);
    chk("rst_busy", 512'({bsy0, bsy1}), 512'd0);
    chk("rst_done", 512'({dn0, dn1}), 512'd0);
    chk("rst_state0", so0, 512'd0);
    chk("rst_state1", so1, 512'd0);
    chk("rst_gabcd0", {ga0, gb0, gc0, gd0}, 512'd0);
    chk("rst_gxy0", 512'({gx0, gy0}), 512'd0);
    chk("rst_gabcd1", {ga1, gb1, gc1, gd1}, 512'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // job A: message word i = i, permutation visible on X/Y
    for (int i = 0; i < 16; i++) mi[32*i +: 32] = 32'(i);
    sa = rand512();
    ea = ref_run(sa, mi, 7);
    start_job(0, sa, mi);
    at_cyc(1);
    chk("r0_col_l0_xy", 512'({gx0[31:0], gy0[31:0]}),
        512'({32'd0, 32'd1}));
    at_cyc(6);
    chk("r0_diag_l0_xy", 512'({gx0[31:0], gy0[31:0]}),
        512'({32'd8, 32'd9}));
    at_cyc(11);
    chk("r1_col_l0_xy", 512'({gx0[31:0], gy0[31:0]}),
        512'({32'd2, 32'd6}));
    chk("r1_col_l1_xy", 512'({gx0[63:32], gy0[63:32]}),
        512'({32'd3, 32'd10}));
    at_cyc(30);
    chk("busy_mid", 512'({bsy0, rdy0}), 512'b10);
    drain(0, 100);
    at_cyc(72);
    chk("ready_after", 512'({rdy0, bsy0, dn0}), 512'b100);
    chk("state_held", so0, ea);

    // Start held high: one accept per IDLE visit, next at cycle 72
    sb = rand512();
    mi = rand512();
    @(negedge clk);
    st0 = 1'b1; si0 = sb; mi0 = mi;
    @(posedge clk);
    #1;
    t0 = cyc - 1;
    e.st = ref_run(sb, mi, 7);
    e.at = t0 + 71;
    q0.push_back(e);
    e.at = t0 + 72 + 71;
    q0.push_back(e);
    at_cyc(100);
    st0 = 1'b0;
    drain(0, 200);

    // reset mid-run aborts; rerun matches an uninterrupted run
    sc = rand512();
    mi = rand512();
    start_job(0, sc, mi);
    at_cyc(30);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q0.delete();
    chk("abort_state_cleared", so0, 512'd0);
    repeat (80) @(negedge clk);
    chk("abort_idle", 512'({rdy0, bsy0}), 512'b10);
    start_job(0, sc, mi);
    drain(0, 100);

    // single-round instance: two steps, done at cycle 11
    sd = rand512();
    mi = rand512();
    start_job(1, sd, mi);
    at_cyc(10);
    chk("u1_busy", 512'({bsy1, dn1}), 512'b10);
    drain(1, 40);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
